// File: rtl/cpu.sv
// cpu: byte-serial-programmed 4-lane int8 vector processor with 64-word imem and 32x32 register file.
module cpu (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o,
  output logic       is_positive,
  output logic [2:0] easter_egg
);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
  state_t      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic [5:0]  pc_q, pc_d;
  logic [1:0]  pos_q, pos_d;
  logic [23:0] part_q, part_d;
  logic [31:0] imem_q [64];
  logic [31:0] regs_q [32];
  logic        imem_we, rf_we;
  logic [5:0]  imem_wa;
  logic [4:0]  rf_wa;
  logic [31:0] imem_wd, rf_wd, ins, a, b, c, sel;
  logic [5:0]  op;
  logic        boundary_ff;

  function automatic logic [31:0] relu(input logic [31:0] x);
    for (int i = 0; i < 4; i++) relu[i*8 +: 8] = x[i*8+7] ? 8'h00 : x[i*8 +: 8];
  endfunction

  function automatic logic [31:0] maxp(input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < 4; i++)
      maxp[i*8 +: 8] = ($signed(x[i*8 +: 8]) > $signed(y[i*8 +: 8])) ? x[i*8 +: 8] : y[i*8 +: 8];
  endfunction

  function automatic logic [31:0] dot(input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + 32'($signed(x[i*8 +: 8]) * $signed(y[i*8 +: 8]));
    dot = s;
  endfunction

  always_ff @(posedge clk_i or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  assign boundary_ff = pos_q == 2'd0 && instr_i == 8'hFF;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = instr_i == 8'hFE ? LOAD : IDLE;
      LOAD: state_d = boundary_ff ? (count_q == 7'd0 ? DONE : EXEC) :
                      (pos_q == 2'd3 && count_q == 7'd63) ? EXEC : LOAD;
      EXEC: state_d = {1'b0, pc_q} == count_q - 7'd1 ? DONE : EXEC;
      default: state_d = DONE;
    endcase
  end

  always_comb easter_egg = {1'b0, state_q};

  assign ins = imem_q[pc_q];
  assign op  = ins[31:26];
  assign a   = regs_q[ins[20:16]];
  assign b   = regs_q[ins[15:11]];
  assign c   = regs_q[ins[25:21]];

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    pos_d   = pos_q;
    part_d  = part_q;
    imem_we = 1'b0;
    imem_wa = count_q[5:0];
    imem_wd = {part_q, instr_i};
    rf_we   = 1'b0;
    rf_wa   = ins[25:21];
    rf_wd   = '0;
    if (state_q == IDLE && instr_i == 8'hFE) begin
      count_d = '0;
      pos_d   = '0;
    end
    if (state_q == LOAD && !boundary_ff) begin
      pos_d   = pos_q + 2'd1;
      part_d  = {part_q[15:0], instr_i};
      imem_we = pos_q == 2'd3;
      count_d = pos_q == 2'd3 ? count_q + 7'd1 : count_q;
    end
    if (state_q == EXEC) begin
      pc_d  = pc_q + 6'd1;
      rf_we = ins[25:21] != 5'd0 && op >= 6'd1 && op <= 6'd8;
      case (op)
        6'd1:    rf_wd = {ins[15:0], c[15:0]};
        6'd2:    rf_wd = {c[31:16], ins[15:0]};
        6'd3:    rf_wd = a + b;
        6'd4:    rf_wd = relu(a);
        6'd5:    rf_wd = maxp(a, b);
        6'd6:    rf_wd = dot(a, b);
        6'd7:    rf_wd = c + dot(a, b);
        default: rf_wd = a;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset)
    if (reset) begin
      count_q <= '0;
      pc_q    <= '0;
      pos_q   <= '0;
      part_q  <= '0;
      for (int i = 0; i < 64; i++) imem_q[i] <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      pos_q   <= pos_d;
      part_q  <= part_d;
      if (imem_we) imem_q[imem_wa] <= imem_wd;
      if (rf_we) regs_q[rf_wa] <= rf_wd;
    end

  always_comb begin
    sel         = DataOrReg ? regs_q[address] : imem_q[{1'b0, address}];
    value_o     = sel[{vout_addr, 3'b000} +: 8];
    is_positive = $signed(sel) > 0;
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for the vector cpu, scoreboarded register expectations checked after DONE.
module tb_cpu;
  logic       clk_i = 0, reset = 0, DataOrReg = 0;
  logic [7:0] instr_i = 0, value_o;
  logic [4:0] address = 0;
  logic [1:0] vout_addr = 0;
  logic       is_positive;
  logic [2:0] easter_egg;
  int checks = 0, errors = 0;

  typedef struct {string tag; logic [4:0] r; logic [31:0] v;} exp_t;
  exp_t sb[$];
  logic [31:0] prog[$];

  cpu dut (.clk_i(clk_i), .reset(reset), .instr_i(instr_i), .DataOrReg(DataOrReg), .address(address),
           .vout_addr(vout_addr), .value_o(value_o), .is_positive(is_positive), .easter_egg(easter_egg));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] fi(input logic [5:0] op, input logic [4:0] rd, input logic [15:0] imm);
    return {op, rd, 5'd0, imm};
  endfunction

  function automatic logic [31:0] fr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
    return {op, rd, s1, s2, 11'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    instr_i = v;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic read_word(input logic dr, input logic [4:0] a, output logic [31:0] w);
    DataOrReg = dr;
    address = a;
    for (int i = 0; i < 4; i++) begin
      vout_addr = 2'(i);
      #1;
      w[i*8 +: 8] = value_o;
    end
  endtask

  task automatic do_reset;
    reset = 1;
    instr_i = 0;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (easter_egg !== 3'd3 && k < 300) begin
      tick();
      k++;
    end
    check("done_cycles", k, n);
  endtask

  task automatic run_prog;
    do_reset();
    send(8'hFE);
    foreach (prog[i]) send_word(prog[i]);
    send(8'hFF);
    wait_done(prog.size());
  endtask

  task automatic drain;
    logic [31:0] w;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      read_word(1'b1, e.r, w);
      check(e.tag, w, e.v);
    end
  endtask

  initial begin
    logic [31:0] w;
    reset = 1;
    #2;
    check("rst_state", easter_egg, 3'd0);
    check("rst_value", value_o, 8'h00);
    check("rst_pos", is_positive, 1'b0);
    reset = 0;
    tick();

    // ReLU, MaxPool and the r0 discard in one program
    prog = '{fi(1, 2, 16'h80FF), fi(2, 2, 16'h0102), fr(4, 4, 2, 0),
             fi(1, 3, 16'h7F00), fi(2, 3, 16'h0380), fr(5, 6, 2, 3), fi(2, 0, 16'h1234)};
    sb.push_back('{"relu_src", 5'd2, 32'h80FF0102});
    sb.push_back('{"relu", 5'd4, 32'h00000102});
    sb.push_back('{"maxp", 5'd6, 32'h7F000302});
    sb.push_back('{"r0", 5'd0, 32'h0});
    run_prog();
    drain();
    read_word(1'b1, 5'd4, w);
    check("relu_pos", is_positive, 1'b1);
    read_word(1'b0, 5'd0, w);
    check("imem0", w, 32'h044080FF);

    // DOT, MAC accumulation and a negative dot product
    prog = '{fi(1, 2, 16'h02FF), fi(2, 2, 16'h0304), fi(1, 3, 16'h0506), fi(2, 3, 16'h0708),
             fr(6, 4, 2, 3), fr(7, 5, 2, 3), fr(7, 5, 2, 3),
             fi(1, 7, 16'h8000), fi(1, 8, 16'h7F00), fr(6, 9, 7, 8)};
    sb.push_back('{"dot", 5'd4, 32'h00000039});
    sb.push_back('{"mac", 5'd5, 32'h00000072});
    sb.push_back('{"dot_neg", 5'd9, 32'hFFFFC080});
    run_prog();
    drain();
    read_word(1'b1, 5'd9, w);
    check("dot_neg_pos", is_positive, 1'b0);
    check("done_state", easter_egg, 3'd3);

    // framing: junk before 0xFE, then immediate 0xFF
    do_reset();
    send(8'h12);
    send(8'h34);
    check("idle_junk", easter_egg, 3'd0);
    send(8'hFE);
    check("load_state", easter_egg, 3'd1);
    send(8'hFF);
    check("empty_done", easter_egg, 3'd3);
    for (int r = 1; r < 32; r += 10) sb.push_back('{"empty_reg", 5'(r), 32'h0});
    drain();
    read_word(1'b0, 5'd0, w);
    check("empty_imem", w, 32'h0);
    send(8'hFE);
    send_word(fi(2, 1, 16'h0001));
    send(8'hFF);
    check("done_hold", easter_egg, 3'd3);
    read_word(1'b1, 5'd1, w);
    check("done_noexec", w, 32'h0);

    // reset mid-LOAD
    do_reset();
    send(8'hFE);
    send_word(fi(2, 1, 16'h1234));
    read_word(1'b0, 5'd0, w);
    check("load_word", w, 32'h08201234);
    send(8'h08);
    send(8'h20);
    vout_addr = 2'd0;
    reset = 1;
    #1;
    check("midrst_state", easter_egg, 3'd0);
    check("midrst_value", value_o, 8'h00);
    tick();
    reset = 0;
    tick();

    // 64 words end loading without 0xFF
    send(8'hFE);
    for (int i = 0; i < 64; i++) send_word(32'h0);
    check("auto_exec", easter_egg, 3'd2);
    wait_done(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Byte-serial-programmed 4-lane int8 vector processor for small CNN kernels (ReLU, max-pool, fully-connected, convolution). It loads a program of 32-bit instructions one byte per clock through `instr_i` and executes it from an internal instruction memory on a 32×32-bit register file. Results are read combinationally one byte at a time through `value_o`. It is the top compute block the chip-level bench drives directly.

## Interface
- No parameters. Fixed sizes: 64-word instruction memory, 32 registers.
- `clk_i` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `instr_i` in 8: program byte stream, sampled on every rising edge.
- `DataOrReg` in 1: readout source; 1 = register file, 0 = instruction memory word `address` (words 0–31).
- `address` in 5: readout register/word index.
- `vout_addr` in 2: readout byte select; 3 = bits [31:24], 0 = bits [7:0].
- `value_o` out 8: selected byte, combinational.
- `is_positive` out 1: 1 iff the selected 32-bit word, taken as signed, is > 0.
- `easter_egg` out 3: state code; IDLE = 0, LOAD = 1, EXEC = 2, DONE = 3.

## Operation
- Lanes: a 32-bit word holds four signed int8 lanes. L3 = [31:24] … L0 = [7:0].
- Instruction fields: op = [31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm16 = [15:0].
- Opcodes:
  - 0x00 NOP.
  - 0x01 LUI: rd[31:16] = imm16; low half kept.
  - 0x02 LLI: rd[15:0] = imm16; high half kept.
  - 0x03 ADD: rd = rs1 + rs2, 32-bit wrap.
  - 0x04 RELU: per lane, rd.Li = (rs1.Li < 0) ? 0 : rs1.Li.
  - 0x05 MAXP: per lane, rd.Li = signed max(rs1.Li, rs2.Li).
  - 0x06 DOT: rd = Σ rs1.Li × rs2.Li, signed 8×8 products, sum sign-extended to 32 bits.
  - 0x07 MAC: rd = rd + DOT(rs1, rs2), 32-bit wrap.
  - 0x08 MOV: rd = rs1.
  - All other opcodes execute as NOP.
  - Opcode 0x3F is reserved, so no instruction's first byte can be 0xFC–0xFF.
- Register r0 reads 0. Writes to r0 are discarded.
- FSM:
  - IDLE: a byte of 0xFE moves to LOAD with word count cleared. All other bytes are ignored.
  - LOAD: bytes are packed MSB-first, four per word, and written to imem[count], then count increments.
    - A byte of 0xFF on a word boundary (first byte position) moves to EXEC.
    - A 0xFF in any other byte position is ordinary data.
    - When count reaches 64, the machine moves to EXEC automatically.
    - A partial word is discarded on 0xFF only if it is at a boundary; otherwise the 0xFF is data.
  - EXEC: one instruction per cycle, pc = 0 … count−1, then DONE. A count of 0 goes straight to DONE.
  - DONE: holds all state. `instr_i` is ignored until reset.
- Readout works in every state. It reflects committed state only (registers as of the last clock edge).

## Timing
- Reset (asynchronous): state IDLE, pc = 0, count = 0, all registers and imem = 0. Hence `value_o` = 0x00, `is_positive` = 0, `easter_egg` = 0.
- Reset asserted mid-LOAD or mid-EXEC aborts immediately, with the same values as above.
- A byte present before edge k is consumed at edge k.
- 0xFE consumed at edge k: LOAD begins. Instruction word j completes at edge k + 4(j+1).
- 0xFF consumed at edge e: EXEC begins. Instruction i writes rd at edge e+1+i. DONE is reached at edge e+count.
- No pipeline and no hazards: instruction i+1 sees the result of instruction i.
- `value_o` and `is_positive` settle combinationally from `DataOrReg`, `address`, `vout_addr` and register state. There is no output register.

## Test plan
- ReLU: program LUI r2,0x80FF (bytes 04 40 80 FF); LLI r2,0x0102 (08 40 01 02); RELU r4,r2 (10 82 00 00); then FF.
  - Required: r2 reads bytes 80,FF,01,02 for `vout_addr` 3→0.
  - Required: r4 reads 00,00,01,02 and `is_positive` = 1.
  - Note the 0xFF data byte inside the first word must not end loading.
- MaxPool: r2 = 0x80FF0102, r3 = 0x7F000380, MAXP r4,r2,r3.
  - Required: r4 = 0x7F000302.
- FC/DOT: r2 = 0x02FF0304, r3 = 0x05060708, DOT r4,r2,r3.
  - Required: r4 = 0x00000039.
  - With r2 = 0x80000000, r3 = 0x7F000000: required r4 = 0xFFFFC080 and `is_positive` = 0.
- Conv/MAC: with the first operands above, r5 = 0, then MAC r5,r2,r3 twice.
  - Required: r5 = 0x00000072.
  - Required: `easter_egg` = 3 after completion.
- Framing and reset:
  - Bytes 12 34 before 0xFE must have no effect.
  - 0xFF sent as the first byte after 0xFE goes to DONE with all registers 0.
  - Reset pulsed mid-LOAD must give `easter_egg` = 0 and `value_o` = 0x00 at once.
- r0 write: LLI r0,0x1234 must leave r0 reading 0.
